unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Merges the core's instruction-fetch port and data port onto one single-port,
//  synchronous-read RAM (1-cycle read latency).
//  Sits between top_riscV (IMEM_*/DMEM_* ports) and the memory array.
//  Grants at most one access per cycle; data has priority, bounded by a fetch-starvation limit.
//  Returns read data to the correct requester with a one-cycle valid pulse.
// PARAMETERS
//  ADDR_WIDTH    10  word-address bits driven to the RAM (mem_addr_o = addr_i[ADDR_WIDTH-1:0])
//  STARVE_LIMIT  4   max consecutive data grants while a fetch is waiting (1..15)
// PORTS
//  clk           in   1            single clock, all state on rising edge
//  reset         in   1            asynchronous, active-high reset
//  imem_req_i    in   1            fetch request; held with imem_addr_i until imem_gnt_o
//  imem_addr_i   in   32           fetch word address
//  imem_gnt_o    out  1            fetch accepted this cycle (combinational)
//  imem_data_o   out  32           fetched word, held until next fetch return
//  imem_valid_o  out  1            1-cycle pulse: imem_data_o updated
//  dmem_read_i   in   1            data load request; held until dmem_gnt_o
//  dmem_write_i  in   1            data store request; held until dmem_gnt_o
//  dmem_addr_i   in   32           data word address
//  dmem_wdata_i  in   32           store data
//  dmem_gnt_o    out  1            data access accepted this cycle (combinational)
//  dmem_rdata_o  out  32           loaded word, held until next load return
//  dmem_valid_o  out  1            1-cycle pulse: dmem_rdata_o updated
//  mem_addr_o    out  ADDR_WIDTH   RAM address
//  mem_re_o      out  1            RAM read enable
//  mem_we_o      out  1            RAM write enable
//  mem_wdata_o   out  32           RAM write data
//  mem_rdata_i   in   32           RAM read data, valid the cycle after mem_re_o
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0; streak counter 0; in-flight tag cleared.
//   A read in flight when reset asserts is discarded; no valid pulse after reset releases.
//  Request merge: dreq = dmem_read_i | dmem_write_i.
//   If read and write are both high, the write wins; the load is ignored for that grant.
//  Arbitration (combinational, each cycle):
//   - dreq & !(imem_req_i & streak==STARVE_LIMIT) -> data grant.
//   - Otherwise, if imem_req_i -> fetch grant.
//   - No request -> idle: mem_re_o = mem_we_o = 0; mem_addr_o, mem_wdata_o = 0.
//  Streak counter:
//   - +1 on a data grant while imem_req_i is high, saturating at STARVE_LIMIT.
//   - Cleared on any fetch grant or any cycle with imem_req_i low.
//  Granted access drives mem_addr_o and exactly one of mem_re_o/mem_we_o in the same cycle.
//   A fetch always drives mem_re_o.
//  Read return: a 1-bit tag register records the owner of a read granted in cycle N.
//   In cycle N+1 the owner's data register captures mem_rdata_i, and its valid pulses in N+2.
//   Load-to-use latency from grant is 2 cycles.
//  Reads are fully pipelined: back-to-back reads (any mix) return in order, one per cycle.
//  Writes produce no valid pulse. A write in cycle N is visible to a read granted in N+1.
//  Address bits above ADDR_WIDTH-1 are ignored (aliasing wrap).
//  The core stalls on !gnt; the arbiter never buffers an ungranted request.
// TESTING
//  1 Fetch only: imem_req=1, addr 0..3, RAM[i]=i+100
//    -> gnt every cycle; imem_valid pulses each cycle from cycle 2; data 100,101,102,103.
//  2 Collision: imem_req & dmem_read same cycle (addr 5 / 9)
//    -> dmem_gnt=1, imem_gnt=0; next cycle imem_gnt=1; dmem_rdata=RAM[9] one cycle before imem_data=RAM[5].
//  3 Starvation: continuous dmem_write + imem_req, STARVE_LIMIT=4
//    -> 4 data grants, 1 fetch grant, repeating; the fetch never waits more than 4 cycles.
//  4 Store then load: write 0xDEADBEEF to addr 7, then read addr 7 next cycle
//    -> dmem_rdata_o=0xDEADBEEF with dmem_valid_o one pulse; no imem_valid.
//  5 Reset mid-read: grant load at addr 3, assert reset the next cycle
//    -> all outputs 0 immediately; no dmem_valid after release; a first fetch after reset returns correctly.
//  6 Aliasing + read/write conflict: addr 0x400 with ADDR_WIDTH=10
//    -> mem_addr_o=0; read|write both high -> mem_we_o=1, mem_re_o=0, no valid pulse.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the core's IMEM/DMEM ports and the single-port RAM port around the
// unified memory arbiter; slave is the arbiter's view, master the core/RAM side.
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 10
) ();
  localparam int unsigned DW = 32;

  logic                  imem_req_i;
  logic [DW-1:0]         imem_addr_i;
  logic                  imem_gnt_o;
  logic [DW-1:0]         imem_data_o;
  logic                  imem_valid_o;

  logic                  dmem_read_i;
  logic                  dmem_write_i;
  logic [DW-1:0]         dmem_addr_i;
  logic [DW-1:0]         dmem_wdata_i;
  logic                  dmem_gnt_o;
  logic [DW-1:0]         dmem_rdata_o;
  logic                  dmem_valid_o;

  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_re_o;
  logic                  mem_we_o;
  logic [DW-1:0]         mem_wdata_o;
  logic [DW-1:0]         mem_rdata_i;

  modport slave (
    input  imem_req_i, imem_addr_i,
    output imem_gnt_o, imem_data_o, imem_valid_o,
    input  dmem_read_i, dmem_write_i, dmem_addr_i, dmem_wdata_i,
    output dmem_gnt_o, dmem_rdata_o, dmem_valid_o,
    output mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output imem_req_i, imem_addr_i,
    input  imem_gnt_o, imem_data_o, imem_valid_o,
    output dmem_read_i, dmem_write_i, dmem_addr_i, dmem_wdata_i,
    input  dmem_gnt_o, dmem_rdata_o, dmem_valid_o,
    input  mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Merges instruction-fetch and data ports onto one synchronous-read RAM:
// data-first arbitration with a fetch-starvation bound, tagged read return.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  reset,
  unified_mem_arbiter_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic                  dreq;
  logic                  starved;
  logic                  dgnt_c;
  logic                  igrant_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic                  re_c;
  logic                  we_c;
  logic [DW-1:0]         wdata_c;

  logic [SW-1:0] streak_q, streak_d;
  logic          tag_vld_q, tag_vld_d;
  logic          tag_dmem_q, tag_dmem_d;
  logic [DW-1:0] idata_q, idata_d;
  logic [DW-1:0] ddata_q, ddata_d;
  logic          ivld_q, ivld_d;
  logic          dvld_q, dvld_d;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^{bus.imem_addr_i[DW-1:ADDR_WIDTH], bus.dmem_addr_i[DW-1:ADDR_WIDTH]};

  // Grant and RAM drive; nothing is granted while reset is held so outputs read 0 at once.
  always_comb begin
    addr_c   = '0;
    re_c     = 1'b0;
    we_c     = 1'b0;
    wdata_c  = '0;
    dreq     = bus.dmem_read_i | bus.dmem_write_i;
    starved  = bus.imem_req_i && (streak_q == LIMIT);
    dgnt_c   = !reset && dreq && !starved;
    igrant_c = !reset && !dgnt_c && bus.imem_req_i;
    if (dgnt_c) begin
      addr_c = bus.dmem_addr_i[ADDR_WIDTH-1:0];
      we_c   = bus.dmem_write_i;
      re_c   = !bus.dmem_write_i;
      if (bus.dmem_write_i) wdata_c = bus.dmem_wdata_i;
    end else if (igrant_c) begin
      addr_c = bus.imem_addr_i[ADDR_WIDTH-1:0];
      re_c   = 1'b1;
    end
  end

  // Streak, read tag and return-path next state.
  always_comb begin
    streak_d   = streak_q;
    tag_vld_d  = re_c;
    tag_dmem_d = dgnt_c;
    ivld_d     = tag_vld_q && !tag_dmem_q;
    dvld_d     = tag_vld_q && tag_dmem_q;
    idata_d    = idata_q;
    ddata_d    = ddata_q;
    if (!bus.imem_req_i || igrant_c) begin
      streak_d = '0;
    end else if (dgnt_c && (streak_q != LIMIT)) begin
      streak_d = streak_q + SW'(1);
    end
    if (ivld_d) idata_d = bus.mem_rdata_i;
    if (dvld_d) ddata_d = bus.mem_rdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q   <= '0;
      tag_vld_q  <= 1'b0;
      tag_dmem_q <= 1'b0;
      idata_q    <= '0;
      ddata_q    <= '0;
      ivld_q     <= 1'b0;
      dvld_q     <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      tag_vld_q  <= tag_vld_d;
      tag_dmem_q <= tag_dmem_d;
      idata_q    <= idata_d;
      ddata_q    <= ddata_d;
      ivld_q     <= ivld_d;
      dvld_q     <= dvld_d;
    end
  end

  assign bus.imem_gnt_o   = igrant_c;
  assign bus.dmem_gnt_o   = dgnt_c;
  assign bus.mem_addr_o   = addr_c;
  assign bus.mem_re_o     = re_c;
  assign bus.mem_we_o     = we_c;
  assign bus.mem_wdata_o  = wdata_c;
  assign bus.imem_data_o  = idata_q;
  assign bus.imem_valid_o = ivld_q;
  assign bus.dmem_rdata_o = ddata_q;
  assign bus.dmem_valid_o = dvld_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of grants, RAM contents and returns.
module tb_unified_mem_arbiter;
  localparam int unsigned AW    = 10;
  localparam int unsigned LIMIT = 4;
  localparam logic [31:0] RMASK = 32'hFFFF_FC1F;

  typedef struct {
    int          due;
    bit          own_d;
    logic [31:0] val;
  } ret_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  unified_mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous-read single-port RAM behind the arbiter.
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (bus.mem_we_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
    if (bus.mem_re_o) bus.mem_rdata_i <= ram[bus.mem_addr_o];
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          m_streak = 0;
  bit          m_ig     = 1'b0;
  bit          m_dg     = 1'b0;
  logic [31:0] h_i      = '0;
  logic [31:0] h_d      = '0;
  logic [31:0] shadow [1024];
  ret_t        rq [$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void check_all(string tag, logic ig, logic dg, logic re, logic we,
                                    logic [31:0] addr, logic [31:0] wd, logic iv, logic dv,
                                    logic [31:0] id, logic [31:0] dd);
    check({tag, "_imem_gnt"},   32'(bus.imem_gnt_o),   32'(ig));
    check({tag, "_dmem_gnt"},   32'(bus.dmem_gnt_o),   32'(dg));
    check({tag, "_mem_re"},     32'(bus.mem_re_o),     32'(re));
    check({tag, "_mem_we"},     32'(bus.mem_we_o),     32'(we));
    check({tag, "_mem_addr"},   32'(bus.mem_addr_o),   addr);
    check({tag, "_mem_wdata"},  bus.mem_wdata_o,       wd);
    check({tag, "_imem_valid"}, 32'(bus.imem_valid_o), 32'(iv));
    check({tag, "_dmem_valid"}, 32'(bus.dmem_valid_o), 32'(dv));
    check({tag, "_imem_data"},  bus.imem_data_o,       id);
    check({tag, "_dmem_rdata"}, bus.dmem_rdata_o,      dd);
  endfunction

  // Reference model for one cycle, evaluated mid-cycle from the current inputs.
  function automatic void model_step();
    bit          ir, rd, wr, e_dg, e_ig, e_re, e_we, e_iv, e_dv;
    logic [9:0]  e_addr;
    logic [31:0] e_wd;
    ret_t        r;
    cyc++;
    if (reset) begin
      check_all("rst", 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      rq.delete();
      h_i = '0; h_d = '0; m_streak = 0; m_ig = 1'b0; m_dg = 1'b0;
      return;
    end
    ir = bus.imem_req_i; rd = bus.dmem_read_i; wr = bus.dmem_write_i;
    e_dg = (rd || wr) && !(ir && m_streak == LIMIT);
    e_ig = !e_dg && ir;
    e_re = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (e_dg) begin
      e_addr = bus.dmem_addr_i[9:0];
      if (wr) begin e_we = 1'b1; e_wd = bus.dmem_wdata_i; end
      else e_re = 1'b1;
    end else if (e_ig) begin
      e_addr = bus.imem_addr_i[9:0];
      e_re = 1'b1;
    end
    e_iv = 1'b0; e_dv = 1'b0;
    if (rq.size() != 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.own_d) begin e_dv = 1'b1; h_d = r.val; end
      else begin e_iv = 1'b1; h_i = r.val; end
    end
    check_all("cyc", e_ig, e_dg, e_re, e_we, 32'(e_addr), e_wd, e_iv, e_dv, h_i, h_d);
    if (e_re) begin
      r.due = cyc + 2; r.own_d = e_dg; r.val = shadow[e_addr];
      rq.push_back(r);
    end
    if (e_we) shadow[e_addr] = e_wd;
    if (!ir || e_ig) m_streak = 0;
    else if (e_dg) m_streak = (m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1;
    m_ig = e_ig; m_dg = e_dg;
  endfunction

  task automatic drive(input logic rst, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] wd);
    reset = rst;
    bus.imem_req_i = ir;   bus.imem_addr_i = ia;
    bus.dmem_read_i = dr;  bus.dmem_write_i = dw;
    bus.dmem_addr_i = da;  bus.dmem_wdata_i = wd;
  endtask

  task automatic step_to_drive();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic rst, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] wd);
    step_to_drive();
    drive(rst, ir, ia, dr, dw, da, wd);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    bit          ip, dp, dr, dw;
    int          k;
    logic [31:0] ia, da, wd;
    for (int a = 0; a < 1024; a++) shadow[a] = '0;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (3) tick(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    idle();

    for (int a = 0; a < 32; a++) tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'(a), $urandom());
    for (int a = 0; a < 4; a++) tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'(a), 32'(100 + a));
    tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'd5, 32'h0000_5555);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'd9, 32'h0000_9999);
    repeat (2) idle();

    // Fetch-only stream, returns from the third cycle on.
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 32'(i), 1'b0, 1'b0, '0, '0);
      check("t1_gnt", 32'(bus.imem_gnt_o), 32'd1);
      if (i >= 2) begin
        check("t1_valid", 32'(bus.imem_valid_o), 32'd1);
        check("t1_data", bus.imem_data_o, 32'(98 + i));
      end
    end
    idle(); check("t1_data", bus.imem_data_o, 32'd102);
    idle(); check("t1_data", bus.imem_data_o, 32'd103);
    idle(); check("t1_valid_end", 32'(bus.imem_valid_o), 32'd0);

    // Collision: data first, fetch next, returns in grant order.
    tick(1'b0, 1'b1, 32'd5, 1'b1, 1'b0, 32'd9, '0);
    check("t2_dgnt", 32'(bus.dmem_gnt_o), 32'd1);
    check("t2_igrant_blocked", 32'(bus.imem_gnt_o), 32'd0);
    tick(1'b0, 1'b1, 32'd5, 1'b0, 1'b0, '0, '0);
    check("t2_igrant", 32'(bus.imem_gnt_o), 32'd1);
    idle();
    check("t2_dvalid", 32'(bus.dmem_valid_o), 32'd1);
    check("t2_drdata", bus.dmem_rdata_o, 32'h0000_9999);
    check("t2_ivalid_early", 32'(bus.imem_valid_o), 32'd0);
    idle();
    check("t2_ivalid", 32'(bus.imem_valid_o), 32'd1);
    check("t2_idata", bus.imem_data_o, 32'h0000_5555);
    repeat (2) idle();

    // Starvation bound: four data grants then one fetch, repeating.
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 1'b1, 32'(i % 16), 1'b0, 1'b1, 32'(40 + i), 32'hA000 + 32'(i));
      check("t3_igrant", 32'(bus.imem_gnt_o), 32'((i % 5) == 4));
      check("t3_dgnt", 32'(bus.dmem_gnt_o), 32'((i % 5) != 4));
    end
    repeat (3) idle();

    // Store then load the same word.
    tick(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'd7, 32'hDEAD_BEEF);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'd7, '0);
    idle(); check("t4_no_write_pulse", 32'(bus.dmem_valid_o), 32'd0);
    idle();
    check("t4_dvalid", 32'(bus.dmem_valid_o), 32'd1);
    check("t4_rdata", bus.dmem_rdata_o, 32'hDEAD_BEEF);
    check("t4_no_ivalid", 32'(bus.imem_valid_o), 32'd0);
    idle(); check("t4_one_pulse", 32'(bus.dmem_valid_o), 32'd0);

    // Reset while a load is in flight.
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'd3, '0);
    check("t5_dgnt", 32'(bus.dmem_gnt_o), 32'd1);
    tick(1'b1, 1'b1, 32'd3, 1'b0, 1'b0, '0, '0);
    check("t5_rst_igrant", 32'(bus.imem_gnt_o), 32'd0);
    check("t5_rst_re", 32'(bus.mem_re_o), 32'd0);
    check("t5_rst_idata", bus.imem_data_o, 32'd0);
    check("t5_rst_ddata", bus.dmem_rdata_o, 32'd0);
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      idle(); check("t5_no_dvalid", 32'(bus.dmem_valid_o), 32'd0);
    end
    tick(1'b0, 1'b1, 32'd3, 1'b0, 1'b0, '0, '0);
    check("t5_igrant", 32'(bus.imem_gnt_o), 32'd1);
    idle(); idle();
    check("t5_ivalid", 32'(bus.imem_valid_o), 32'd1);
    check("t5_idata", bus.imem_data_o, 32'd103);

    // Aliased address with read and write both raised.
    tick(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h0000_0400, 32'h1234_5678);
    check("t6_addr", 32'(bus.mem_addr_o), 32'd0);
    check("t6_we", 32'(bus.mem_we_o), 32'd1);
    check("t6_re", 32'(bus.mem_re_o), 32'd0);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h0000_0400, '0);
    check("t6_rd_addr", 32'(bus.mem_addr_o), 32'd0);
    idle(); check("t6_no_pulse", 32'(bus.dmem_valid_o), 32'd0);
    idle();
    check("t6_dvalid", 32'(bus.dmem_valid_o), 32'd1);
    check("t6_rdata", bus.dmem_rdata_o, 32'h1234_5678);
    repeat (2) idle();

    // Random traffic; requests are held until the model says they were granted.
    ip = 1'b0; dp = 1'b0; dr = 1'b0; dw = 1'b0; ia = '0; da = '0; wd = '0;
    for (int c = 0; c < 3000; c++) begin
      step_to_drive();
      if (ip && m_ig) ip = 1'b0;
      if (dp && m_dg) dp = 1'b0;
      if (!ip && $urandom_range(0, 3) != 0) begin
        ip = 1'b1;
        ia = $urandom() & RMASK;
      end
      if (!dp && $urandom_range(0, 1) == 0) begin
        dp = 1'b1;
        k  = int'($urandom_range(0, 3));
        dr = (k != 1);
        dw = (k == 1) || (k == 2);
        da = $urandom() & RMASK;
        wd = $urandom();
      end
      drive(1'b0, ip, ia, dp && dr, dp && dw, da, wd);
    end
    repeat (4) idle();
    step_to_drive();
    check("drain_empty", 32'(rq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
